ascii_enc: RTL and testbench
============================

ASCII_ENC -- requirements
Module: ascii_enc

Interface
REQ-001 The block SHALL have parameter ASCII_WIDTH, default 7, character code width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 11, font line address width.
REQ-003 The block SHALL have parameter LINES, default 11, font lines per character.
REQ-004 The block SHALL have parameter FIRST_CHAR, default 32, lowest printable code.
REQ-005 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port inValid  in  1  request present.
REQ-008 The block SHALL have port inReady  out  1  block accepts a request.
REQ-009 The block SHALL have port charaLineAddr  in  ADDR_WIDTH  font line address to decode.
REQ-010 The block SHALL have port outValid  out  1  result present.
REQ-011 The block SHALL have port outReady  in  1  consumer takes the result.
REQ-012 The block SHALL have port ascii  out  ASCII_WIDTH  recovered character code.
REQ-013 The block SHALL have port lineCnt  out  4  recovered line index 0..LINES-1.
REQ-014 The block SHALL have port addrErr  out  1  address outside the font range.

Function
REQ-015 The block SHALL invert the font address map: ascii = addr/LINES + FIRST_CHAR, lineCnt = addr mod LINES, for addr 0..(128-FIRST_CHAR)*LINES-1 (0..1055).
REQ-016 The block SHALL implement states IDLE, DIV, DONE.
REQ-017 inReady SHALL be 1 only in IDLE; a request is accepted on an edge where inValid && inReady.
REQ-018 On accept, an in-range address SHALL be latched, the remainder register loaded, and the state SHALL become DIV with the bit counter at ASCII_WIDTH-1.
REQ-019 Each DIV cycle SHALL produce one quotient bit MSB-first by restoring division: if the partial remainder >= LINES shifted to the current bit, subtract it and set the bit; else clear the bit.
REQ-020 After exactly ASCII_WIDTH (7) DIV cycles the state SHALL become DONE with outValid=1; outValid is therefore first high 7 cycles after the accept edge.
REQ-021 On accept, an address >= 1056 SHALL go directly to DONE on the next edge with addrErr=1, ascii=0, lineCnt=0.
REQ-022 In DONE, ascii, lineCnt, addrErr SHALL hold stable while outReady=0.
REQ-023 DONE with outReady=1 SHALL return to IDLE on that edge; outValid drops; a new request is not accepted in that same cycle.
REQ-024 The quotient SHALL be 7 bits (max 95) and the final remainder SHALL be at most 4 bits; FIRST_CHAR is added after division with no overflow for in-range addresses.
REQ-025 inValid and charaLineAddr SHALL be ignored outside IDLE.
REQ-026 Outputs SHALL be registered; no combinational path from charaLineAddr to ascii/lineCnt.

Reset
REQ-027 While rst=1 at a rising edge the state SHALL become IDLE, and outValid=0, inReady=1 after that edge, with ascii=0, lineCnt=0, addrErr=0.
REQ-028 Reset asserted in DIV or DONE SHALL abandon the request with no result emitted.

Structure
REQ-029 ASCII_WIDTH, ADDR_WIDTH, LINES, FIRST_CHAR defaults and the state encoding SHALL live in a shared font package also used by the forward address decoder.
REQ-030 One sub-module, div_step (combinational single restoring-division step: remainder in, divisor shift in, remainder out, quotient bit out), is natural; the FSM and registers stay in ascii_enc.

Verification
REQ-031 The bench SHALL cover: addr 0 -> ascii 32, lineCnt 0, addrErr 0, outValid 7 cycles after accept.
REQ-032 The bench SHALL cover: addr 365 -> ascii 65, lineCnt 2; addr 1055 -> ascii 127, lineCnt 10.
REQ-033 The bench SHALL cover: addr 1056 and 2047 -> addrErr 1, ascii 0, lineCnt 0, outValid 1 cycle after accept.
REQ-034 The bench SHALL cover: outReady held 0 for 20 cycles in DONE -> outputs constant, inReady 0, and a changing charaLineAddr has no effect.
REQ-035 The bench SHALL cover: rst pulsed during the 4th DIV cycle -> IDLE, outValid 0, and the next request (addr 11 -> ascii 33, lineCnt 0) decodes correctly.
REQ-036 The bench SHALL cover: round trip over all ascii 32..127 and lineCnt 0..10 through the forward map (ascii-32)*11+lineCnt -> original pair recovered exactly.

Source files
------------

// File: rtl/ascii_enc_pkg.sv
// Shared font constants, FSM state encoding and the forward character/line -> address map.
package ascii_enc_pkg;

    localparam int unsigned AsciiWidth = 7;
    localparam int unsigned AddrWidth  = 11;
    localparam int unsigned Lines      = 11;
    localparam int unsigned FirstChar  = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
        StDone = 2'd2
    } enc_state_e;

    // Forward map used by the font address decoder: line address of (ascii, line).
    function automatic logic [AddrWidth-1:0] font_addr(input logic [AsciiWidth-1:0] ascii,
                                                       input logic [3:0] line);
        font_addr = AddrWidth'((int'(ascii) - int'(FirstChar)) * int'(Lines) + int'(line));
    endfunction

endpackage

// File: rtl/ascii_enc_div_step.sv
// One combinational restoring-division step: subtract the shifted divisor when it fits.
module ascii_enc_div_step #(
    parameter int unsigned W = 18
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] div_in,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    always_comb begin
        q_bit   = (rem_in >= div_in);
        rem_out = q_bit ? (rem_in - div_in) : rem_in;
    end

endmodule

// File: rtl/ascii_enc.sv
// Inverts the font line address map: addr -> (addr / LINES + FIRST_CHAR, addr mod LINES).
module ascii_enc
    import ascii_enc_pkg::*;
#(
    parameter int unsigned ASCII_WIDTH = AsciiWidth,
    parameter int unsigned ADDR_WIDTH  = AddrWidth,
    parameter int unsigned LINES       = Lines,
    parameter int unsigned FIRST_CHAR  = FirstChar
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [ADDR_WIDTH-1:0]  charaLineAddr,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [ASCII_WIDTH-1:0] ascii,
    output logic [3:0]             lineCnt,
    output logic                   addrErr
);

    localparam int unsigned DW      = ADDR_WIDTH + ASCII_WIDTH;
    localparam int unsigned CW      = $clog2(ASCII_WIDTH);
    localparam int unsigned MaxAddr = ((1 << ASCII_WIDTH) - FIRST_CHAR) * LINES;

    enc_state_e             state_q;
    logic [DW-1:0]          rem_q;
    logic [ASCII_WIDTH-1:0] quot_q;
    logic [CW-1:0]          bit_cnt_q;
    logic                   err_q;

    logic [DW-1:0]          div_shift;
    logic [DW-1:0]          rem_next;
    logic                   q_bit;
    logic [ASCII_WIDTH-1:0] quot_next;
    logic                   in_range;

    always_comb begin
        div_shift = DW'(LINES) << bit_cnt_q;
        in_range  = (DW'(charaLineAddr) < DW'(MaxAddr));
        quot_next = quot_q;
        quot_next[bit_cnt_q] = q_bit;
    end

    ascii_enc_div_step #(
        .W (DW)
    ) u_div_step (
        .rem_in  (rem_q),
        .div_in  (div_shift),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quot_q    <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
            inReady   <= 1'b1;
            outValid  <= 1'b0;
            ascii     <= '0;
            lineCnt   <= '0;
            addrErr   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inValid) begin
                        state_q <= StDiv;
                        inReady <= 1'b0;
                        quot_q  <= '0;
                        err_q   <= ~in_range;
                        rem_q   <= DW'(charaLineAddr);
                        // Out-of-range requests spend a single cycle in StDiv before reporting.
                        bit_cnt_q <= in_range ? CW'(ASCII_WIDTH - 1) : '0;
                    end
                end
                StDiv: begin
                    quot_q <= quot_next;
                    rem_q  <= rem_next;
                    if (err_q) begin
                        state_q  <= StDone;
                        outValid <= 1'b1;
                        ascii    <= '0;
                        lineCnt  <= '0;
                        addrErr  <= 1'b1;
                    end else if (bit_cnt_q == '0) begin
                        state_q  <= StDone;
                        outValid <= 1'b1;
                        ascii    <= quot_next + ASCII_WIDTH'(FIRST_CHAR);
                        lineCnt  <= rem_next[3:0];
                        addrErr  <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end
                end
                StDone: begin
                    if (outReady) begin
                        state_q  <= StIdle;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_enc.sv
// Self-checking bench for ascii_enc: vector table, corner sequences and full round trip.
module tb_ascii_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [10:0] charaLineAddr;
    logic        outValid;
    logic        outReady;
    logic [6:0]  ascii;
    logic [3:0]  lineCnt;
    logic        addrErr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [10:0] addr;
        int          ascii;
        int          line;
        bit          err;
        int          lat;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    ascii_enc #(
        .ASCII_WIDTH (7),
        .ADDR_WIDTH  (11),
        .LINES       (11),
        .FIRST_CHAR  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inValid       (inValid),
        .inReady       (inReady),
        .charaLineAddr (charaLineAddr),
        .outValid      (outValid),
        .outReady      (outReady),
        .ascii         (ascii),
        .lineCnt       (lineCnt),
        .addrErr       (addrErr)
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one request, accept it on the next edge and queue its expectation.
    task automatic send(input logic [10:0] a, input int ea, input int el, input bit ee,
                        input int elat);
        vec_t v;
        int   n = 0;
        @(negedge clk);
        while (!inReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", int'(inReady), 1);
        inValid       = 1'b1;
        charaLineAddr = a;
        @(posedge clk);
        v = '{addr: a, ascii: ea, line: el, err: ee, lat: elat};
        exp_q.push_back(v);
        #1 inValid = 1'b0;
    endtask

    // Wait (bounded) for the result, check latency and pop the scoreboard.
    task automatic collect();
        vec_t v;
        int   cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!outValid && cyc < 30);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        v = exp_q.pop_front();
        if (!outValid) begin
            check("out_timeout", cyc, v.lat);
            return;
        end
        check($sformatf("latency_%0d", v.addr), cyc, v.lat);
        check($sformatf("ascii_%0d", v.addr), int'(ascii), v.ascii);
        check($sformatf("line_%0d", v.addr), int'(lineCnt), v.line);
        check($sformatf("err_%0d", v.addr), int'(addrErr), int'(v.err));
    endtask

    task automatic release_out();
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1 outReady = 1'b0;
        check("release_outvalid", int'(outValid), 0);
        check("release_inready", int'(inReady), 1);
    endtask

    task automatic run_req(input logic [10:0] a, input int ea, input int el, input bit ee,
                           input int elat);
        send(a, ea, el, ee, elat);
        collect();
        release_out();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 11'd0,    ascii: 32,  line: 0,  err: 1'b0, lat: 7};
        vecs[1] = '{addr: 11'd365,  ascii: 65,  line: 2,  err: 1'b0, lat: 7};
        vecs[2] = '{addr: 11'd1055, ascii: 127, line: 10, err: 1'b0, lat: 7};
        vecs[3] = '{addr: 11'd1056, ascii: 0,   line: 0,  err: 1'b1, lat: 1};
        vecs[4] = '{addr: 11'd2047, ascii: 0,   line: 0,  err: 1'b1, lat: 1};
        vecs[5] = '{addr: 11'd11,   ascii: 33,  line: 0,  err: 1'b0, lat: 7};
        vecs[6] = '{addr: 11'd10,   ascii: 32,  line: 10, err: 1'b0, lat: 7};
        vecs[7] = '{addr: 11'd1045, ascii: 127, line: 0,  err: 1'b0, lat: 7};
        vecs[8] = '{addr: 11'd123,  ascii: 43,  line: 2,  err: 1'b0, lat: 7};

        rst           = 1'b1;
        inValid       = 1'b0;
        outReady      = 1'b0;
        charaLineAddr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_inready", int'(inReady), 1);
        check("rst_outvalid", int'(outValid), 0);
        check("rst_ascii", int'(ascii), 0);
        check("rst_line", int'(lineCnt), 0);
        check("rst_err", int'(addrErr), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_req(vecs[i].addr, vecs[i].ascii, vecs[i].line, vecs[i].err, vecs[i].lat);
        end

        // Hold in DONE with outReady low while inputs wiggle.
        send(11'd700, 95, 7, 1'b0, 7);
        collect();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            inValid       = 1'b1;
            charaLineAddr = 11'($urandom);
            @(posedge clk);
            #1;
            check("hold_ascii", int'(ascii), 95);
            check("hold_line", int'(lineCnt), 7);
            check("hold_err", int'(addrErr), 0);
            check("hold_outvalid", int'(outValid), 1);
            check("hold_inready", int'(inReady), 0);
        end
        inValid = 1'b0;
        release_out();

        // DONE -> IDLE edge with a pending request: accepted only on the following edge.
        send(11'd22, 34, 0, 1'b0, 7);
        collect();
        @(negedge clk);
        outReady      = 1'b1;
        inValid       = 1'b1;
        charaLineAddr = 11'd24;
        @(posedge clk);
        #1 outReady = 1'b0;
        check("handoff_outvalid", int'(outValid), 0);
        check("handoff_inready", int'(inReady), 1);
        @(posedge clk);
        exp_q.push_back('{addr: 11'd24, ascii: 34, line: 2, err: 1'b0, lat: 7});
        #1 inValid = 1'b0;
        check("handoff_accepted", int'(inReady), 0);
        collect();
        release_out();

        // Reset during the 4th DIV cycle abandons the request.
        send(11'd500, 77, 5, 1'b0, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_outvalid", int'(outValid), 0);
        check("midrst_inready", int'(inReady), 1);
        check("midrst_ascii", int'(ascii), 0);
        check("midrst_line", int'(lineCnt), 0);
        check("midrst_err", int'(addrErr), 0);
        rst = 1'b0;
        run_req(11'd11, 33, 0, 1'b0, 7);

        // Round trip through the forward map.
        for (int a = 32; a < 128; a++) begin
            for (int l = 0; l < 11; l++) begin
                run_req(11'((a - 32) * 11 + l), a, l, 1'b0, 7);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
